fifo_rd_stream: RTL
===================

# fifo_rd_stream

Read-side consumer for the asynchronous FIFO, in the read clock domain. Converts the FIFO's `r_en`/`empty`/`data_out` pop interface, with its one-cycle read latency, into a valid/ready stream with a two-entry output buffer. Sustains one word per cycle when the FIFO is non-empty and the sink is ready, and never loses a word under backpressure.

## Interface
- `DATA_WIDTH`, default 8: word width; must match the FIFO.
- `rclk`  in  1: read-domain clock; all logic is on its rising edge.
- `rrst_n`  in  1: asynchronous active-low reset. Assertion is asynchronous; deassertion is synchronous to `rclk`.
- `fifo_empty`  in  1: FIFO `empty` flag, already in the `rclk` domain.
- `fifo_rdata`  in  DATA_WIDTH: FIFO `data_out`. Valid in the cycle after `r_en` is sampled high.
- `fifo_r_en`  out  1: pop request to the FIFO.
- `m_valid`  out  1: output word available.
- `m_ready`  in  1: sink accepts the word.
- `m_data`  out  DATA_WIDTH: head word of the output buffer.
- `rd_count`  out  32: words delivered. Present only with `FIFO_RD_STATS_EN`.

## Operation
- State:
  - `occ` (0..2): buffer occupancy.
  - `inflight` (1 bit): `fifo_r_en` was high last cycle.
  - `buf0` is the head entry; `buf1` is the tail entry.
- Occupancy states: EMPTY (`occ`=0), ONE (`occ`=1), TWO (`occ`=2).
- `pop` = `m_valid & m_ready`.
- `fifo_r_en` is combinational: `!fifo_empty && (occ + inflight - pop) < 2`.
  - It is never asserted while `fifo_empty`=1.
- `inflight` is registered from `fifo_r_en`.
- When `inflight`=1, `fifo_rdata` is written into the buffer at the slot after the head, accounting for the same-cycle `pop`:
  - ONE + pop + capture: `buf0` <= `fifo_rdata`; state stays ONE.
  - ONE + capture, no pop: `buf1` <= `fifo_rdata`; state goes to TWO.
  - EMPTY + capture: `buf0` <= `fifo_rdata`; state goes to ONE.
  - TWO + pop + capture: `buf0` <= `buf1`, `buf1` <= `fifo_rdata`; state stays TWO.
  - TWO + capture, no pop: cannot occur, because the credit rule prevents it.
- Pop without capture: `buf0` <= `buf1`, and `occ` decrements.
- `m_valid` = (`occ` != 0). `m_data` = `buf0`.
- `m_data` and `m_valid` stay stable while `m_valid & !m_ready`.
- Ordering is strict FIFO order. No word is dropped or duplicated.
- Illegal transitions do not occur. If `occ` = 2 and a capture arrives without a pop, that is a design error; the bench asserts on it.

## Timing
- Reset values: `occ`=0, `inflight`=0, `fifo_r_en`=0, `m_valid`=0, `m_data`=0, `rd_count`=0, buffers=0.
- Latency from `fifo_empty` falling to `m_valid` rising is 2 cycles:
  - `fifo_r_en` asserts in the same cycle `fifo_empty` falls.
  - The data is captured on the next edge.
  - `m_valid` rises the cycle after that.
- Throughput: 1 word/cycle with `m_ready`=1 and the FIFO continuously non-empty.
- Backpressure: after `m_ready` drops, at most the words already in flight are accepted and the buffer holds ≤2 words. `fifo_r_en` then stays low until `pop`.
- `fifo_empty` may rise in the cycle after a pop. Any in-flight word is still captured.
- Reset mid-operation: all state clears immediately. An in-flight word is discarded; the FIFO is reset alongside it in the same domain.

## Configuration
- Macro: `FIFO_RD_STATS_EN`.
- Defined: adds output `rd_count`, a 32-bit count of `pop` events that wraps from 0xFFFF_FFFF to 0. It resets to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Reset with `fifo_empty`=1 → `fifo_r_en`=0, `m_valid`=0, `m_data`=0 for 10 cycles.
- FIFO holds 0x11,0x22,0x33 and `m_ready`=1 → `m_data` 0x11,0x22,0x33 on 3 consecutive cycles; first `m_valid` 2 cycles after `fifo_empty` falls.
- 8 words queued, `m_ready`=0 for 6 cycles, then 1 → exactly 2 words buffered, `fifo_r_en`=0 during the stall, `m_data` held. All 8 words are then delivered in order with no gaps.
- `m_ready` toggling 1/0 every cycle with 16 words → output order 0..15, `fifo_r_en` never high while `fifo_empty`=1.
- `rrst_n` pulsed low while `occ`=2 and `inflight`=1 → outputs are 0 within the same cycle, and the next word after reset is the first word written post-reset.
- With `FIFO_RD_STATS_EN` defined: 5 pops → `rd_count`=5. Preload 0xFFFF_FFFF, then one pop → 0.

Source files
------------

// File: rtl/fifo_rd_stream.sv
// Read-side FIFO consumer: turns the FIFO's r_en/empty pop port (one-cycle read latency)
// into a valid/ready stream via a two-entry buffer. Optional pop counter: FIFO_RD_STATS_EN.
module fifo_rd_stream #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  fifo_r_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data
`ifdef FIFO_RD_STATS_EN
    ,
    output logic [31:0]           rd_count
`endif
);

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_t;

    occ_t                  occ_reg, occ_next;
    logic                  inflight_reg;
    logic [DATA_WIDTH-1:0] buf0_reg, buf0_next;
    logic [DATA_WIDTH-1:0] buf1_reg, buf1_next;
    logic                  pop;
    logic [2:0]            credit;

    assign m_valid = (occ_reg != OCC_EMPTY);
    assign m_data  = buf0_reg;
    assign pop     = m_valid & m_ready;

    // Words held plus the word already on its way, less the one leaving this cycle.
    assign credit    = {1'b0, occ_reg} + {2'b00, inflight_reg} - {2'b00, pop};
    assign fifo_r_en = !fifo_empty && (credit < 3'd2);

    always_comb begin
        occ_next  = occ_reg;
        buf0_next = buf0_reg;
        buf1_next = buf1_reg;
        case ({inflight_reg, pop})
            2'b10: begin
                if (occ_reg == OCC_EMPTY) begin
                    buf0_next = fifo_rdata;
                    occ_next  = OCC_ONE;
                end else begin
                    buf1_next = fifo_rdata;
                    occ_next  = OCC_TWO;
                end
            end
            2'b11: begin
                if (occ_reg == OCC_TWO) begin
                    buf0_next = buf1_reg;
                    buf1_next = fifo_rdata;
                end else begin
                    buf0_next = fifo_rdata;
                end
            end
            2'b01: begin
                buf0_next = buf1_reg;
                occ_next  = (occ_reg == OCC_TWO) ? OCC_ONE : OCC_EMPTY;
            end
            default: ;
        endcase
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            occ_reg      <= OCC_EMPTY;
            inflight_reg <= 1'b0;
            buf0_reg     <= '0;
            buf1_reg     <= '0;
        end else begin
            occ_reg      <= occ_next;
            inflight_reg <= fifo_r_en;
            buf0_reg     <= buf0_next;
            buf1_reg     <= buf1_next;
        end
    end

`ifdef FIFO_RD_STATS_EN
    logic [31:0] rd_count_reg;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rd_count_reg <= '0;
        end else if (pop) begin
            rd_count_reg <= rd_count_reg + 32'd1;
        end
    end

    assign rd_count = rd_count_reg;
`endif

endmodule
